// File: rtl/encoder_m.sv
// Instruction-word encoder with a single output register stage and a word-address counter.
// Build option: define ENCODER_RANGE_CHECK_EN to reject immediates outside their field range.
module encoder_m (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [5:0]  shamt,
  input  logic [1:0]  hw,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic [7:0]  instr_addr,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        addr_load,
  input  logic [7:0]  addr_base,
  input  logic        err_clr,
  output logic        err_illegal,
  output logic        err_range
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_SUBI = 4'd5;
  localparam logic [3:0] OP_LDUR = 4'd6;
  localparam logic [3:0] OP_STUR = 4'd7;
  localparam logic [3:0] OP_CBZ  = 4'd8;
  localparam logic [3:0] OP_CBNZ = 4'd9;
  localparam logic [3:0] OP_B    = 4'd10;
  localparam logic [3:0] OP_BL   = 4'd11;
  localparam logic [3:0] OP_MOVK = 4'd12;

  logic [31:0] r_instr;
  logic [7:0]  r_addr;
  logic        r_out_valid;
  logic        r_err_illegal;
  logic        r_err_range;

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_oor_raw;
  logic        w_oor;
  logic        w_accept;
  logic        w_handshake;
  logic        w_emit;
  logic signed [31:0] w_simm;

  assign w_simm      = $signed(imm);
  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = r_out_valid && out_ready;

  always_comb begin
    w_word    = '0;
    w_illegal = 1'b0;
    w_oor_raw = 1'b0;
    case (op_sel)
      OP_ADD:  w_word = {11'b10001011000, rm, shamt, rn, rd};
      OP_SUB:  w_word = {11'b11001011000, rm, shamt, rn, rd};
      OP_AND:  w_word = {11'b10001010000, rm, shamt, rn, rd};
      OP_ORR:  w_word = {11'b10101010000, rm, shamt, rn, rd};
      OP_ADDI, OP_SUBI: begin
        w_word    = {(op_sel == OP_ADDI) ? 10'b1001000100 : 10'b1101000100,
                     imm[11:0], rn, rd};
        w_oor_raw = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
      end
      OP_LDUR, OP_STUR: begin
        w_word    = {(op_sel == OP_LDUR) ? 11'b11111000010 : 11'b11111000000,
                     imm[8:0], 2'b00, rn, rd};
        w_oor_raw = (w_simm < -32'sd256) || (w_simm > 32'sd255);
      end
      OP_CBZ, OP_CBNZ: begin
        w_word    = {(op_sel == OP_CBZ) ? 8'b10110100 : 8'b10110101, imm[18:0], rd};
        w_oor_raw = (w_simm < -32'sd262144) || (w_simm > 32'sd262143);
      end
      OP_B, OP_BL: begin
        w_word    = {(op_sel == OP_B) ? 6'b000101 : 6'b100101, imm[25:0]};
        w_oor_raw = (w_simm < -32'sd33554432) || (w_simm > 32'sd33554431);
      end
      OP_MOVK: begin
        w_word    = {9'b111100101, hw, imm[15:0], rd};
        w_oor_raw = (imm[31:16] != 16'd0);
      end
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  assign w_oor = w_oor_raw;
`else
  // Without range checking the immediate is simply truncated to its field.
  logic w_unused_oor;
  assign w_unused_oor = w_oor_raw;
  assign w_oor        = 1'b0;
`endif

  assign w_emit = !w_illegal && !w_oor;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr       <= '0;
      r_addr        <= '0;
      r_out_valid   <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_range   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= w_emit;
        if (w_emit) r_instr <= w_word;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A load overrides the post-handshake increment; the departing word keeps its address.
      if (addr_load)        r_addr <= addr_base;
      else if (w_handshake) r_addr <= r_addr + 8'd1;

      if (w_accept && w_illegal) r_err_illegal <= 1'b1;
      else if (err_clr)          r_err_illegal <= 1'b0;

      if (w_accept && w_oor) r_err_range <= 1'b1;
      else if (err_clr)      r_err_range <= 1'b0;
    end
  end

  assign instr       = r_instr;
  assign instr_addr  = r_addr;
  assign out_valid   = r_out_valid;
  assign err_illegal = r_err_illegal;
  assign err_range   = r_err_range;

endmodule

// File: tb/tb_encoder_m.sv
// Directed self-checking bench for encoder_m; expectations follow ENCODER_RANGE_CHECK_EN.
module tb_encoder_m;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rd, rn, rm;
  logic [5:0]  shamt;
  logic [1:0]  hw;
  logic [31:0] imm;
  logic [31:0] instr;
  logic [7:0]  instr_addr;
  logic        out_valid;
  logic        out_ready;
  logic        addr_load;
  logic [7:0]  addr_base;
  logic        err_clr;
  logic        err_illegal;
  logic        err_range;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  encoder_m dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .shamt(shamt), .hw(hw), .imm(imm),
    .instr(instr), .instr_addr(instr_addr), .out_valid(out_valid), .out_ready(out_ready),
    .addr_load(addr_load), .addr_base(addr_base), .err_clr(err_clr),
    .err_illegal(err_illegal), .err_range(err_range)
  );

  // Hand-computed vectors, streamed back-to-back.
  localparam int NV = 13;
  logic [3:0]  t_op [NV] = '{4'd4, 4'd6, 4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
  logic [4:0]  t_rd [NV] = '{5'd1, 5'd5, 5'd3, 5'd4, 5'd0, 5'd31, 5'd2, 5'd1, 5'd7, 5'd0, 5'd0, 5'd0, 5'd9};
  logic [4:0]  t_rn [NV] = '{5'd2, 5'd6, 5'd1, 5'd5, 5'd0, 5'd31, 5'd3, 5'd2, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [4:0]  t_rm [NV] = '{5'd0, 5'd0, 5'd2, 5'd6, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [5:0]  t_sh [NV] = '{6'd0, 6'd0, 6'd0, 6'd3, 6'd0, 6'd63, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
  logic [1:0]  t_hw [NV] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
  logic [31:0] t_imm[NV] = '{32'd5, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF00,
                             32'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h100, 32'hABCD};
  logic [31:0] t_exp[NV] = '{32'h91001441, 32'hF84080C5, 32'h8B020023, 32'hCB060CA4, 32'h8A1F0000,
                             32'hAA00FFFF, 32'hD13FFC62, 32'hF8100041, 32'hB4000067, 32'hB5FFFFC0,
                             32'h17FFFFFF, 32'h94000100, 32'hF2D579A9};

  task automatic set_req(input logic [3:0] op, input logic [4:0] d, input logic [4:0] n,
                         input logic [4:0] m, input logic [5:0] sh, input logic [1:0] h,
                         input logic [31:0] im);
    op_sel = op; rd = d; rn = n; rm = m; shamt = sh; hw = h; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_base = '0;
    err_clr = 1'b0; op_sel = '0; rd = '0; rn = '0; rm = '0; shamt = '0; hw = '0; imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (instr !== 32'd0) begin n_mis++; $display("FAIL rst_instr got %h want 0", instr); end
    n_cmp++; if (instr_addr !== 8'd0) begin n_mis++; $display("FAIL rst_addr got %h want 0", instr_addr); end
    n_cmp++; if ({err_illegal, err_range} !== 2'b00) begin n_mis++; $display("FAIL rst_errs got %b want 00", {err_illegal, err_range}); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    do_reset();
    for (int i = 0; i < NV; i++) begin
      set_req(t_op[i], t_rd[i], t_rn[i], t_rm[i], t_sh[i], t_hw[i], t_imm[i]);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || instr !== t_exp[i] || instr_addr !== i[7:0] || in_ready !== 1'b1) begin
        n_mis++;
        $display("FAIL vec%0d got v=%b instr=%h addr=%0d rdy=%b want v=1 instr=%h addr=%0d rdy=1",
                 i, out_valid, instr, instr_addr, in_ready, t_exp[i], i);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || instr_addr !== 8'(NV)) begin
      n_mis++; $display("FAIL vec_drain got v=%b addr=%0d want v=0 addr=%0d", out_valid, instr_addr, NV);
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    addr_load = 1'b1; addr_base = 8'd255;
    step();
    addr_load = 1'b0;
    n_cmp++; if (instr_addr !== 8'd255) begin n_mis++; $display("FAIL load_addr got %0d want 255", instr_addr); end
    set_req(4'd10, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'hFFFFFFFF);
    step();
    n_cmp++;
    if (instr !== 32'h17FFFFFF || instr_addr !== 8'd255) begin
      n_mis++; $display("FAIL wrap_first got %h@%0d want 17ffffff@255", instr, instr_addr);
    end
    set_req(4'd11, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'h100);
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (instr !== 32'h94000100 || instr_addr !== 8'd0) begin
      n_mis++; $display("FAIL wrap_second got %h@%0d want 94000100@0", instr, instr_addr);
    end
    // Load coinciding with the handshake of the word at address 0.
    addr_load = 1'b1; addr_base = 8'h40;
    step();
    addr_load = 1'b0;
    n_cmp++;
    if (instr_addr !== 8'h40 || out_valid !== 1'b0) begin
      n_mis++; $display("FAIL load_vs_inc got addr=%h v=%b want addr=40 v=0", instr_addr, out_valid);
    end
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    out_ready = 1'b0;
    set_req(4'd0, 5'd3, 5'd1, 5'd2, 6'd0, 2'd0, 32'd0);
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || instr !== 32'h8B020023 || in_ready !== 1'b0) begin
      n_mis++; $display("FAIL stall_first got v=%b instr=%h rdy=%b want v=1 8b020023 rdy=0", out_valid, instr, in_ready);
    end
    set_req(4'd1, 5'd4, 5'd5, 5'd6, 6'd3, 2'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || instr !== 32'h8B020023 || instr_addr !== 8'd0 || in_ready !== 1'b0) begin
        n_mis++; $display("FAIL stall_hold%0d got v=%b instr=%h addr=%0d rdy=%b want v=1 8b020023 0 rdy=0",
                          k, out_valid, instr, instr_addr, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL stall_release_rdy got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || instr !== 32'hCB060CA4 || instr_addr !== 8'd1) begin
      n_mis++; $display("FAIL stall_second got v=%b %h@%0d want v=1 cb060ca4@1", out_valid, instr, instr_addr);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || instr_addr !== 8'd2) begin
      n_mis++; $display("FAIL stall_drain got v=%b addr=%0d want v=0 addr=2", out_valid, instr_addr);
    end
  endtask

  task automatic test_errors();
    do_reset();
    set_req(4'd14, 5'd1, 5'd2, 5'd3, 6'd0, 2'd0, 32'd0);
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || err_illegal !== 1'b1 || err_range !== 1'b0 || instr_addr !== 8'd0) begin
      n_mis++; $display("FAIL illegal got v=%b ill=%b rng=%b addr=%0d want 0 1 0 0", out_valid, err_illegal, err_range, instr_addr);
    end
    step();
    n_cmp++; if (err_illegal !== 1'b1) begin n_mis++; $display("FAIL illegal_sticky got %b want 1", err_illegal); end
    err_clr = 1'b1;
    set_req(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'd0);
    step();
    in_valid = 1'b0;
    n_cmp++; if (err_illegal !== 1'b1) begin n_mis++; $display("FAIL clr_vs_new got %b want 1", err_illegal); end
    step();
    err_clr = 1'b0;
    n_cmp++; if (err_illegal !== 1'b0) begin n_mis++; $display("FAIL illegal_clr got %b want 0", err_illegal); end

    set_req(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 2'd0, 32'd4096);
    step();
    in_valid = 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
    n_cmp++;
    if (out_valid !== 1'b0 || err_range !== 1'b1 || err_illegal !== 1'b0) begin
      n_mis++; $display("FAIL range_addi got v=%b rng=%b ill=%b want 0 1 0", out_valid, err_range, err_illegal);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_cmp++; if (err_range !== 1'b0) begin n_mis++; $display("FAIL range_clr got %b want 0", err_range); end
`else
    n_cmp++;
    if (out_valid !== 1'b1 || instr !== 32'h91000041 || err_range !== 1'b0) begin
      n_mis++; $display("FAIL trunc_addi got v=%b %h rng=%b want 1 91000041 0", out_valid, instr, err_range);
    end
`endif
    set_req(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 2'd0, 32'd2047);
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || instr !== 32'h911FFC41 || err_range !== 1'b0) begin
      n_mis++; $display("FAIL addi_max got v=%b %h rng=%b want 1 911ffc41 0", out_valid, instr, err_range);
    end
    set_req(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 2'd0, 32'hFFFFF800);
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || instr !== 32'h91200041 || err_range !== 1'b0) begin
      n_mis++; $display("FAIL addi_min got v=%b %h rng=%b want 1 91200041 0", out_valid, instr, err_range);
    end
    set_req(4'd12, 5'd9, 5'd0, 5'd0, 6'd0, 2'd2, 32'h10000);
    step();
    in_valid = 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
    n_cmp++;
    if (out_valid !== 1'b0 || err_range !== 1'b1) begin
      n_mis++; $display("FAIL range_movk got v=%b rng=%b want 0 1", out_valid, err_range);
    end
`else
    n_cmp++;
    if (out_valid !== 1'b1 || instr !== 32'hF2C00009 || err_range !== 1'b0) begin
      n_mis++; $display("FAIL trunc_movk got v=%b %h rng=%b want 1 f2c00009 0", out_valid, instr, err_range);
    end
`endif
  endtask

  task automatic test_reset_while_stalled();
    do_reset();
    addr_load = 1'b1; addr_base = 8'h22;
    step();
    addr_load = 1'b0;
    out_ready = 1'b0;
    set_req(4'd0, 5'd3, 5'd1, 5'd2, 6'd0, 2'd0, 32'd0);
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || instr_addr !== 8'h22) begin
      n_mis++; $display("FAIL pre_reset got v=%b addr=%h want 1 22", out_valid, instr_addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || instr_addr !== 8'd0 || instr !== 32'd0) begin
      n_mis++; $display("FAIL async_reset got v=%b addr=%h instr=%h want 0 0 0", out_valid, instr_addr, instr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mis++; $display("FAIL post_reset got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_addr_wrap();
    test_back_to_back_stall();
    test_errors();
    test_reset_while_stalled();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
